// File: rtl/demux_1_4.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_4
// Description : Registered 1-to-4 demultiplexer with valid/ready handshakes.
//               Each input word is steered into one of four holding registers
//               that drain independently.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_4 #(
    parameter int NB_DATA = 32,
    parameter int NB_SEL  = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NB_DATA-1:0] data_i,
    input  logic [NB_SEL-1:0]  sel_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [NB_DATA-1:0] data1_o,
    output logic [NB_DATA-1:0] data2_o,
    output logic [NB_DATA-1:0] data3_o,
    output logic [NB_DATA-1:0] data4_o,
    output logic               valid1_o,
    output logic               valid2_o,
    output logic               valid3_o,
    output logic               valid4_o,
    input  logic               ready1_i,
    input  logic               ready2_i,
    input  logic               ready3_i,
    input  logic               ready4_i
);

    localparam int C_NUM_CH = 4;

    logic [C_NUM_CH-1:0] w_ready_ch;
    logic [C_NUM_CH-1:0] w_valid_ch;
    logic [NB_DATA-1:0]  w_data_ch [C_NUM_CH];
    logic                w_in_xfer;

    assign w_ready_ch = {ready4_i, ready3_i, ready2_i, ready1_i};

    // Acceptance depends only on the addressed channel, so a stalled consumer
    // never blocks words headed to the other three.
    assign ready_o   = !reset_i && (!w_valid_ch[sel_i] || w_ready_ch[sel_i]);
    assign w_in_xfer = valid_i && ready_o;

    generate
        for (genvar i = 0; i < C_NUM_CH; i++) begin : g_chan
            logic [NB_DATA-1:0] r_data;
            logic               r_valid;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else if (w_in_xfer && (sel_i == NB_SEL'(i))) begin
                    // A same-cycle drain is covered: the old word leaves and
                    // the new one takes its place with valid kept high.
                    r_data  <= data_i;
                    r_valid <= 1'b1;
                end else if (w_ready_ch[i]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_valid_ch[i] = r_valid;
            assign w_data_ch[i]  = r_data;
        end
    endgenerate

    assign data1_o  = w_data_ch[0];
    assign data2_o  = w_data_ch[1];
    assign data3_o  = w_data_ch[2];
    assign data4_o  = w_data_ch[3];
    assign valid1_o = w_valid_ch[0];
    assign valid2_o = w_valid_ch[1];
    assign valid3_o = w_valid_ch[2];
    assign valid4_o = w_valid_ch[3];

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1_4
// Description : Self-checking bench for demux_1_4 against a per-channel
//               queue scoreboard, with directed scenarios and random stress.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic [1:0]  sel;
    logic        valid_in;
    logic [3:0]  rdy;
    logic        ready_o;
    logic [31:0] d1, d2, d3, d4;
    logic        v1, v2, v3, v4;

    int checks = 0;
    int errors = 0;

    logic [31:0] q [4][$];

    demux_1_4 #(.NB_DATA(32), .NB_SEL(2)) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .data_i   (din),
        .sel_i    (sel),
        .valid_i  (valid_in),
        .ready_o  (ready_o),
        .data1_o  (d1),
        .data2_o  (d2),
        .data3_o  (d3),
        .data4_o  (d4),
        .valid1_o (v1),
        .valid2_o (v2),
        .valid3_o (v3),
        .valid4_o (v4),
        .ready1_i (rdy[0]),
        .ready2_i (rdy[1]),
        .ready3_i (rdy[2]),
        .ready4_i (rdy[3])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] out_data(input int n);
        case (n)
            0: return d1;
            1: return d2;
            2: return d3;
            default: return d4;
        endcase
    endfunction

    function automatic logic out_valid(input int n);
        case (n)
            0: return v1;
            1: return v2;
            2: return v3;
            default: return v4;
        endcase
    endfunction

    // One clock cycle: compare outputs with the scoreboard for the inputs
    // currently applied, then advance the scoreboard across the edge.
    task automatic step();
        logic        exp_ready;
        logic        acc;
        logic [3:0]  drain;
        logic [1:0]  s_sel;
        logic [31:0] s_din;
        logic        s_rst;
        #1;
        exp_ready = !reset && (q[sel].size() == 0 || rdy[sel]);
        check("ready_o", {31'd0, ready_o}, {31'd0, exp_ready});
        for (int n = 0; n < 4; n++) begin
            check($sformatf("valid%0d", n + 1), {31'd0, out_valid(n)},
                  {31'd0, q[n].size() != 0});
            if (q[n].size() != 0)
                check($sformatf("data%0d", n + 1), out_data(n), q[n][0]);
        end
        acc   = valid_in && exp_ready;
        s_sel = sel;
        s_din = din;
        s_rst = reset;
        for (int n = 0; n < 4; n++)
            drain[n] = (q[n].size() != 0) && rdy[n];
        @(posedge clk);
        #1;
        if (s_rst) begin
            for (int n = 0; n < 4; n++) q[n].delete();
        end else begin
            for (int n = 0; n < 4; n++)
                if (drain[n]) void'(q[n].pop_front());
            if (acc) q[s_sel].push_back(s_din);
        end
    endtask

    initial begin
        logic        pend;
        reset    = 1'b1;
        din      = '0;
        sel      = '0;
        valid_in = 1'b0;
        rdy      = 4'h0;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;
        #1;
        for (int n = 0; n < 4; n++) begin
            check("rst_valid", {31'd0, out_valid(n)}, 32'd0);
            check("rst_data", out_data(n), 32'd0);
        end

        // Single write to an empty channel with its consumer stalled
        valid_in = 1'b1; sel = 2'b10; din = 32'hA5A5_0003; rdy = 4'h0;
        #1 check("t1_ready", {31'd0, ready_o}, 32'd1);
        step();
        valid_in = 1'b0;
        #1;
        check("t1_data3", d3, 32'hA5A5_0003);
        check("t1_valid3", {31'd0, v3}, 32'd1);
        check("t1_others", {29'd0, v1, v2, v4}, 32'd0);
        check("t1_d1", d1, 32'd0);

        // Full channel blocks its own select only
        valid_in = 1'b1; sel = 2'b10; din = 32'h11;
        #1 check("t2_blocked", {31'd0, ready_o}, 32'd0);
        step();
        check("t2_hold3", d3, 32'hA5A5_0003);
        sel = 2'b00;
        #1 check("t2_other", {31'd0, ready_o}, 32'd1);
        step();
        valid_in = 1'b0;
        #1 check("t2_data1", d1, 32'h11);
        rdy = 4'hF;
        step();
        step();

        // Back-to-back streaming into channel 2
        rdy = 4'b0010; sel = 2'b01; valid_in = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            din = k;
            #1 check("t3_ready", {31'd0, ready_o}, 32'd1);
            step();
            check("t3_data2", d2, k);
            check("t3_valid2", {31'd0, v2}, 32'd1);
        end
        valid_in = 1'b0;
        step();

        // Fill and drain on the same channel in one cycle
        rdy = 4'h0; sel = 2'b11; din = 32'h55; valid_in = 1'b1;
        step();
        rdy = 4'b1000; din = 32'h66;
        step();
        valid_in = 1'b0; rdy = 4'h0;
        #1;
        check("t4_data4", d4, 32'h66);
        check("t4_valid4", {31'd0, v4}, 32'd1);
        check("t4_depth", q[3].size(), 32'd1);

        // Reset with all four channels holding stalled words
        for (int s = 0; s < 4; s++) begin
            valid_in = 1'b1; sel = 2'(s); din = 32'h100 + s;
            step();
        end
        reset = 1'b1; sel = 2'b00;
        #1 check("t5_rst_ready", {31'd0, ready_o}, 32'd0);
        step();
        reset = 1'b0; valid_in = 1'b0;
        #1;
        for (int n = 0; n < 4; n++) begin
            check("t5_valid", {31'd0, out_valid(n)}, 32'd0);
            check("t5_data", out_data(n), 32'd0);
        end
        valid_in = 1'b1; sel = 2'b00; din = 32'h77;
        #1 check("t5_accept", {31'd0, ready_o}, 32'd1);
        step();
        valid_in = 1'b0;
        #1 check("t5_data1", d1, 32'h77);

        // Random stress; the producer holds its word until it is accepted
        pend = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            reset = ($urandom_range(0, 999) == 0);
            if (!pend) begin
                valid_in = $urandom_range(0, 1)[0];
                sel      = 2'($urandom_range(0, 3));
                din      = $urandom;
            end
            rdy = 4'($urandom_range(0, 15));
            #1;
            pend = valid_in && !ready_o && !reset;
            step();
        end
        reset = 1'b0; valid_in = 1'b0; rdy = 4'hF;
        step();
        step();
        for (int n = 0; n < 4; n++)
            check("final_empty", q[n].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
